burst_accumulator: RTL
======================

// Module: burst_accumulator
// PURPOSE
//   Sequential consumer of the ripple-carry adder datapath. Accepts a burst of WIDTH-bit
//   operands over a valid/ready handshake and adds each operand plus its carry-in into
//   a running WIDTH-bit sum. When the burst ends, presents the sum, a sticky overflow
//   flag and the operand count on a valid/ready output. Sits downstream of the operand
//   source and upstream of result consumers such as display and compare blocks.
// PARAMETERS
//   WIDTH    4    operand/sum width in bits (>=2)
//   MAX_OPS  15   max operands per burst; the burst is force-terminated at this count (>=1)
//   CW       $clog2(MAX_OPS+1)   derived localparam; width of the count field
// PORTS
//   clk        in   1      rising-edge clock, single clock domain
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      operand present
//   in_ready   out  1      block can accept an operand this cycle
//   in_data    in   WIDTH  operand
//   in_cin     in   1      carry-in added with this operand
//   in_last    in   1      operand is final of burst (qualified by accept)
//   out_valid  out  1      result present
//   out_ready  in   1      consumer takes result this cycle
//   out_sum    out  WIDTH  accumulated sum mod 2^WIDTH
//   out_ovf    out  1      sticky: some add in burst produced carry out of MSB
//   out_count  out  CW     number of operands accepted in burst
// BEHAVIOUR
//   Reset/clock: one clock; reset is synchronous and active-high.
//   Reset values: state=ACCUM, acc=0, ovf=0, count=0, out_valid=0, in_ready=1.
//   States:
//   - ACCUM: in_ready=1, out_valid=0.
//   - DONE:  in_ready=0, out_valid=1.
//   Accept: accept = in_valid & in_ready.
//   - On accept: {c, acc} <= acc + in_data + in_cin, computed at WIDTH+1 bits.
//   - On accept: ovf <= ovf | c; count <= count+1.
//   - No accept: acc, ovf and count hold.
//   ACCUM->DONE: on an accept with in_last=1, or on an accept where count==MAX_OPS-1
//     (forced end). The updated acc/ovf/count appear on the outputs in the next cycle,
//     with out_valid=1. Latency = 1 cycle from the last accept.
//   DONE->ACCUM: on out_valid & out_ready. The same edge clears acc, ovf and count, and
//     in_ready=1 in the following cycle.
//   No operand is accepted in the cycle of the output handshake.
//   DONE hold:
//   - out_sum/out_ovf/out_count remain stable until the handshake.
//   - in_valid, in_data and in_last are ignored.
//   Throughput: one operand per cycle in ACCUM. Bubbles (in_valid=0) allowed mid-burst.
//   Wrap: sum wraps mod 2^WIDTH; carries are not lost, they set ovf. A carry from
//     in_cin alone counts as overflow.
//   Boundaries:
//   - MAX_OPS=1: every accept ends the burst.
//   - in_last together with the forced end: single termination, no double count.
//   - An empty burst is impossible; DONE is entered only via an accept.
//   - reset has priority over all events. Mid-burst or in DONE it discards partial or
//     pending results and forces the reset values.
//   out_sum, out_ovf and out_count drive acc, ovf and count directly (registered outputs);
//     no combinational path from inputs to outputs.
// TESTING  (WIDTH=4, MAX_OPS=4 unless stated)
//   1 reset 2 cycles -> out_valid=0, in_ready=1; then operands 3,4,5 (last on 5),
//     cin=0 -> next cycle out_valid=1, out_sum=12, out_ovf=0, out_count=3.
//   2 Operands 9, 8 (last on 8) -> out_sum=1, out_ovf=1, out_count=2.
//     Operand 7 with cin=1, last -> out_sum=8, out_ovf=0, out_count=1.
//   3 Operands 1,1,1,1 with in_last=0 -> forced end: out_sum=4, out_count=4.
//     The 5th in_valid sees in_ready=0.
//   4 Backpressure: result ready, out_ready=0 for 5 cycles, in_valid pulsed -> outputs
//     stable, in_ready=0, no accept. Raise out_ready 1 cycle -> in_ready=1 next cycle,
//     and a new operand 2 (last) -> out_sum=2.
//   5 Bubbles: operands 6, gap 3 cycles, 5 (last) -> out_sum=11, out_count=2.
//   6 reset asserted after 2 of 3 operands (and again while in DONE) -> reset values
//     next cycle. Burst 2 (last) -> out_sum=2, out_count=1, out_ovf=0.

Source files
------------

// File: rtl/burst_accumulator.sv
// Burst accumulator: sums a handshaked burst of operands plus carry-ins and
// presents sum, sticky overflow and operand count as one registered result.
module burst_accumulator #(
    parameter int WIDTH = 4,
    parameter int MAX_OPS = 15,
    localparam int CW = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_cin,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic [CW-1:0]    out_count
);

    typedef enum logic {
        ACCUM,
        DONE
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_OPS - 1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic             ovf;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   sum;
    logic             accept;
    logic             ends;

    assign accept = in_valid & in_ready;
    assign sum    = {1'b0, acc} + {1'b0, in_data} + {{WIDTH{1'b0}}, in_cin};
    // in_last and the forced end collapse into one termination
    assign ends   = in_last | (count == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACCUM;
            acc       <= '0;
            ovf       <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        acc   <= sum[WIDTH-1:0];
                        ovf   <= ovf | sum[WIDTH];
                        count <= count + CW'(1);
                        if (ends) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        acc       <= '0;
                        ovf       <= 1'b0;
                        count     <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign out_sum   = acc;
    assign out_ovf   = ovf;
    assign out_count = count;

endmodule
